// File: rtl/envo_pkg.sv
// Shared definitions for the evolution-engine scheduler: command bit map,
// engine op codes, FSM encoding and speed limits.
package envo_pkg;

  // Bit positions within the one-hot command pulse bus
  localparam int CMD_CLR     = 0;
  localparam int CMD_INC_V   = 1;
  localparam int CMD_DEC_V   = 2;
  localparam int CMD_RANDOM  = 5;
  localparam int CMD_RUN_TOG = 6;
  localparam int CMD_STEP    = 7;

  // Speed level range
  localparam int              SPEED_W   = 3;
  localparam logic [SPEED_W-1:0] SPEED_RST = 3'd3;
  localparam logic [SPEED_W-1:0] SPEED_MAX = 3'd7;

  // Operation codes presented to the engine alongside eng_start
  typedef enum logic [1:0] {
    OP_GEN  = 2'd0,
    OP_CLR  = 2'd1,
    OP_RAND = 2'd2
  } eng_op_e;

  // Scheduler states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_SWAP  = 2'd3
  } state_e;

endpackage

// File: rtl/envo_scheduler_gen_timer.sv
// Generation timer: a free-running prescaler produces a 1 ms tick, and an
// interval counter turns ticks into a gen_req pulse every 2^(MAX_SHIFT-speed)
// ticks while running. Levels at or above MAX_SHIFT fire on every tick.
module gen_timer
  import envo_pkg::*;
#(
  parameter int TICK_DIV  = 100000,
  parameter int MAX_SHIFT = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               running,
  input  logic [SPEED_W-1:0] speed,
  input  logic               reload,
  output logic               gen_req
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = MAX_SHIFT + 1;

  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic [IW-1:0] iv_cnt;
  logic [IW-1:0] limit;

  // Interval length in ticks for the current speed level
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    limit = IW'(1);
    if (int'(speed) < MAX_SHIFT) begin
      limit = IW'(1) << (MAX_SHIFT - int'(speed));
    end
  end

  // Prescaler: one-cycle tick every TICK_DIV clocks
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else if (pre_cnt == PW'(TICK_DIV - 1)) begin
      pre_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
      tick    <= 1'b0;
    end
  end

  // Interval counter: held at zero when stopped or reloaded
  always_ff @(posedge clk) begin
    if (rst || reload || !running) begin
      iv_cnt  <= '0;
      gen_req <= 1'b0;
    end else if (tick) begin
      if (iv_cnt + IW'(1) >= limit) begin
        iv_cnt  <= '0;
        gen_req <= 1'b1;
      end else begin
        iv_cnt  <= iv_cnt + IW'(1);
        gen_req <= 1'b0;
      end
    end else begin
      gen_req <= 1'b0;
    end
  end

endmodule

// File: rtl/envo_scheduler.sv
// Evolution-engine scheduler: collects clear / random / generation requests
// into one-deep pending flags, issues them to the engine one at a time and
// swaps the display buffer during vertical blank once each op completes.
module envo_scheduler
  import envo_pkg::*;
#(
  parameter int TICK_DIV  = 100000,
  parameter int MAX_SHIFT = 10,
  parameter int TIMEOUT   = 1 << 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         cmd,
  input  logic               vblank,
  input  logic               eng_done,
  output logic [1:0]         eng_op,
  output logic               eng_start,
  output logic               buf_swap,
  output logic               running,
  output logic               busy,
  output logic [SPEED_W-1:0] speed,
  output logic [15:0]        gen_count,
  output logic               err
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e             state;
  eng_op_e            cur_op;
  logic               p_clr;
  logic               p_rand;
  logic               p_gen;
  logic [TW-1:0]      to_cnt;
  logic [SPEED_W-1:0] speed_next;
  logic               inc_v;
  logic               dec_v;
  logic               reload;
  logic               gen_req;
  logic               unused_edit_bits;

  assign inc_v            = cmd[CMD_INC_V];
  assign dec_v            = cmd[CMD_DEC_V];
  assign unused_edit_bits = ^cmd[4:3];
  assign eng_op           = cur_op;

  // Saturating speed update; simultaneous INC and DEC cancel
  always_comb begin
    speed_next = speed;
    if (inc_v && !dec_v && speed != SPEED_MAX) begin
      speed_next = speed + SPEED_W'(1);
    end else if (dec_v && !inc_v && speed != '0) begin
      speed_next = speed - SPEED_W'(1);
    end
  end

  // Restart the generation interval whenever the pacing changes
  assign reload = (speed_next != speed) | cmd[CMD_RUN_TOG];

  gen_timer #(
    .TICK_DIV  (TICK_DIV),
    .MAX_SHIFT (MAX_SHIFT)
  ) u_gen_timer (
    .clk     (clk),
    .rst     (rst),
    .running (running),
    .speed   (speed),
    .reload  (reload),
    .gen_req (gen_req)
  );

  // Speed level and free-run enable
  always_ff @(posedge clk) begin
    if (rst) begin
      speed   <= SPEED_RST;
      running <= 1'b0;
    end else begin
      speed <= speed_next;
      if (cmd[CMD_RUN_TOG]) begin
        running <= ~running;
      end
    end
  end

  // Transaction FSM with pending-request flags; a request arriving in the
  // same cycle its flag is consumed re-arms the flag (sets are applied last)
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cur_op    <= OP_GEN;
      eng_start <= 1'b0;
      buf_swap  <= 1'b0;
      busy      <= 1'b0;
      gen_count <= '0;
      err       <= 1'b0;
      to_cnt    <= '0;
      p_clr     <= 1'b0;
      p_rand    <= 1'b0;
      p_gen     <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      buf_swap  <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (p_clr || p_rand || p_gen) begin
            state     <= ST_ISSUE;
            eng_start <= 1'b1;
            busy      <= 1'b1;
            if (p_clr) begin
              cur_op <= OP_CLR;
              p_clr  <= 1'b0;
            end else if (p_rand) begin
              cur_op <= OP_RAND;
              p_rand <= 1'b0;
            end else begin
              cur_op <= OP_GEN;
              p_gen  <= 1'b0;
            end
          end
        end

        ST_ISSUE: begin
          to_cnt <= TW'(TIMEOUT - 1);
          state  <= ST_WAIT;
        end

        ST_WAIT: begin
          if (eng_done) begin
            state <= ST_SWAP;
          end else if (to_cnt == '0) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt - TW'(1);
          end
        end

        ST_SWAP: begin
          if (vblank) begin
            buf_swap  <= 1'b1;
            gen_count <= (cur_op == OP_GEN) ? gen_count + 16'd1 : 16'd0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase

      if (cmd[CMD_CLR]) begin
        p_clr <= 1'b1;
      end
      if (cmd[CMD_RANDOM]) begin
        p_rand <= 1'b1;
      end
      if (cmd[CMD_STEP] || gen_req) begin
        p_gen <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_envo_scheduler.sv
// Directed self-checking bench for envo_scheduler with a fast timebase.
module tb_envo_scheduler;
  import envo_pkg::*;

  localparam int TICK_DIV  = 4;
  localparam int MAX_SHIFT = 4;
  localparam int TIMEOUT   = 64;

  localparam logic [7:0] C_CLR  = 8'h01;
  localparam logic [7:0] C_INC  = 8'h02;
  localparam logic [7:0] C_DEC  = 8'h04;
  localparam logic [7:0] C_RAND = 8'h20;
  localparam logic [7:0] C_RUN  = 8'h40;
  localparam logic [7:0] C_STEP = 8'h80;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cmd;
  logic        vblank;
  logic        eng_done;
  logic [1:0]  eng_op;
  logic        eng_start;
  logic        buf_swap;
  logic        running;
  logic        busy;
  logic [2:0]  speed;
  logic [15:0] gen_count;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  envo_scheduler #(
    .TICK_DIV  (TICK_DIV),
    .MAX_SHIFT (MAX_SHIFT),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cmd),
    .vblank    (vblank),
    .eng_done  (eng_done),
    .eng_op    (eng_op),
    .eng_start (eng_start),
    .buf_swap  (buf_swap),
    .running   (running),
    .busy      (busy),
    .speed     (speed),
    .gen_count (gen_count),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    cmd      = 8'h00;
    eng_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_cmd(input logic [7:0] bits);
    cmd = bits;
    @(negedge clk);
    cmd = 8'h00;
  endtask

  task automatic give_done();
    eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
  endtask

  // Poll for eng_start; returns at the negedge where it is seen
  task automatic wait_start(input string tag, input eng_op_e exp_op, output int t_seen);
    bit found = 1'b0;
    t_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (eng_start) begin
        found  = 1'b1;
        t_seen = cyc;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_start_seen"}, 32'(found), 32'd1);
    if (found) check({tag, "_op"}, 32'(eng_op), 32'(exp_op));
  endtask

  task automatic wait_swap(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (buf_swap) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_swap_seen"}, 32'(found), 32'd1);
  endtask

  // Answer any op still issuing so the DUT settles in IDLE
  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (eng_start) begin
        @(negedge clk);
        give_done();
      end
    end
  endtask

  int t_prev;
  int t_now;
  int n_ev;

  initial begin
    vblank = 1'b1;
    do_reset();

    // Reset state
    check("rst_eng_op",    32'(eng_op),    32'd0);
    check("rst_eng_start", 32'(eng_start), 32'd0);
    check("rst_buf_swap",  32'(buf_swap),  32'd0);
    check("rst_running",   32'(running),   32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_speed",     32'(speed),     32'd3);
    check("rst_gen_count", 32'(gen_count), 32'd0);
    check("rst_err",       32'(err),       32'd0);

    // Free run at speed 3: GEN every 2 ticks = 8 clocks
    pulse_cmd(C_RUN);
    check("run_on", 32'(running), 32'd1);
    t_prev = 0;
    for (int k = 1; k <= 3; k++) begin
      wait_start($sformatf("run%0d", k), OP_GEN, t_now);
      if (k > 1) check($sformatf("run%0d_period", k), 32'(t_now - t_prev), 32'd8);
      t_prev = t_now;
      @(negedge clk);
      check($sformatf("run%0d_start_1cyc", k), 32'(eng_start), 32'd0);
      check($sformatf("run%0d_busy", k), 32'(busy), 32'd1);
      give_done();
      wait_swap($sformatf("run%0d", k));
      check($sformatf("run%0d_gen_count", k), 32'(gen_count), 32'(k));
    end
    pulse_cmd(C_RUN);
    check("run_off", 32'(running), 32'd0);
    drain(30);
    n_ev = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (eng_start) n_ev++;
    end
    check("stopped_no_start", 32'(n_ev), 32'd0);
    check("stopped_busy", 32'(busy), 32'd0);

    // Speed saturation and cancellation
    do_reset();
    repeat (6) pulse_cmd(C_INC);
    check("speed_sat_hi", 32'(speed), 32'd7);
    repeat (9) pulse_cmd(C_DEC);
    check("speed_sat_lo", 32'(speed), 32'd0);
    pulse_cmd(C_INC | C_DEC);
    check("speed_both_at0", 32'(speed), 32'd0);
    pulse_cmd(C_INC);
    check("speed_inc1", 32'(speed), 32'd1);
    pulse_cmd(C_INC | C_DEC);
    check("speed_both_at1", 32'(speed), 32'd1);

    // Swap held off until vblank
    do_reset();
    vblank = 1'b0;
    pulse_cmd(C_STEP);
    wait_start("vb", OP_GEN, t_now);
    @(negedge clk);
    give_done();
    n_ev = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (buf_swap) n_ev++;
    end
    check("vb_low_no_swap", 32'(n_ev), 32'd0);
    check("vb_low_busy", 32'(busy), 32'd1);
    vblank = 1'b1;
    n_ev = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (buf_swap) n_ev++;
    end
    check("vb_high_one_swap", 32'(n_ev), 32'd1);
    check("vb_high_busy", 32'(busy), 32'd0);
    check("vb_gen_count", 32'(gen_count), 32'd1);

    // CLR and RANDOM arriving while a GEN is in flight
    do_reset();
    pulse_cmd(C_STEP);
    wait_start("pri_gen", OP_GEN, t_now);
    pulse_cmd(C_CLR);
    pulse_cmd(C_CLR);
    pulse_cmd(C_RAND);
    check("pri_busy_in_wait", 32'(busy), 32'd1);
    give_done();
    wait_swap("pri_gen");
    check("pri_gen_count", 32'(gen_count), 32'd1);
    wait_start("pri_clr", OP_CLR, t_now);
    @(negedge clk);
    give_done();
    wait_swap("pri_clr");
    check("pri_clr_count", 32'(gen_count), 32'd0);
    wait_start("pri_rand", OP_RAND, t_now);
    @(negedge clk);
    give_done();
    wait_swap("pri_rand");
    check("pri_rand_count", 32'(gen_count), 32'd0);
    n_ev = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (eng_start) n_ev++;
    end
    check("pri_no_extra_start", 32'(n_ev), 32'd0);

    // gen_count wraps from 0xFFFF
    do_reset();
    force dut.gen_count = 16'hFFFF;
    @(negedge clk);
    release dut.gen_count;
    pulse_cmd(C_STEP);
    wait_start("wrap", OP_GEN, t_now);
    @(negedge clk);
    give_done();
    wait_swap("wrap");
    check("wrap_gen_count", 32'(gen_count), 32'd0);

    // Engine timeout
    do_reset();
    pulse_cmd(C_STEP);
    wait_start("to_pre", OP_GEN, t_now);
    @(negedge clk);
    give_done();
    wait_swap("to_pre");
    check("to_pre_count", 32'(gen_count), 32'd1);
    pulse_cmd(C_STEP);
    wait_start("to", OP_GEN, t_now);
    n_ev = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (buf_swap) n_ev++;
    end
    check("to_early_busy", 32'(busy), 32'd1);
    check("to_early_err", 32'(err), 32'd0);
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      @(negedge clk);
      if (buf_swap) n_ev++;
    end
    check("to_busy", 32'(busy), 32'd0);
    check("to_err", 32'(err), 32'd1);
    check("to_no_swap", 32'(n_ev), 32'd0);
    check("to_count_kept", 32'(gen_count), 32'd1);
    pulse_cmd(C_STEP);
    wait_start("to_after", OP_GEN, t_now);
    @(negedge clk);
    give_done();
    wait_swap("to_after");
    check("to_after_count", 32'(gen_count), 32'd2);
    check("to_err_sticky", 32'(err), 32'd1);
    do_reset();
    check("to_err_cleared", 32'(err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
